// File: rtl/per_addr_decoder.sv
// Routes master requests by address to NB_SLAVES peripheral ports or an error port,
// returns responses in order and synthesises an error response on a response timeout.
module per_addr_decoder #(
  parameter int NB_SLAVES = 4,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 5,
  parameter int MAX_OUT   = 4,
  parameter int TIMEOUT   = 16,
  parameter logic [NB_SLAVES-1:0][ADDR_W-1:0] BASE = {32'h1A11_0000, 32'h1A10_0000,
                                                      32'h1A10_1000, 32'h1A10_0000},
  parameter logic [NB_SLAVES-1:0][ADDR_W-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_0000,
                                                      32'hFFFF_F000, 32'hFFFF_F000}
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_req,
  input  logic [ADDR_W-1:0]                i_add,
  input  logic                             i_wen,
  input  logic [31:0]                      i_wdata,
  input  logic [3:0]                       i_be,
  input  logic [ID_W-1:0]                  i_id,
  output logic                             o_gnt,
  output logic                             o_r_valid,
  output logic                             o_r_opc,
  output logic [ID_W-1:0]                  o_r_id,
  output logic [31:0]                      o_r_rdata,
  output logic [NB_SLAVES:0]               o_req,
  output logic [ADDR_W-1:0]                o_add,
  output logic                             o_wen,
  output logic [31:0]                      o_wdata,
  output logic [3:0]                       o_be,
  output logic [ID_W-1:0]                  o_id,
  input  logic [NB_SLAVES:0]               i_gnt,
  input  logic [NB_SLAVES:0]               i_r_valid,
  input  logic [NB_SLAVES:0]               i_r_opc,
  input  logic [NB_SLAVES:0][ID_W-1:0]     i_r_id,
  input  logic [NB_SLAVES:0][31:0]         i_r_rdata,
  output logic                             o_err_timeout,
  output logic                             o_err_unexp
);

  localparam int NP    = NB_SLAVES + 1;
  localparam int SEL_W = $clog2(NP);
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [PTR_W:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [SEL_W-1:0] fifo_q [MAX_OUT];
  logic [SEL_W-1:0] fifo_d [MAX_OUT];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_pend_q, to_pend_d;
  logic             err_to_q, err_to_d;
  logic             err_unexp_q, err_unexp_d;

  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] head;
  logic [NP-1:0]    head_oh;
  logic             empty, full, head_vld, push, pop, unexp_hit;

  assign o_add   = i_add;
  assign o_wen   = i_wen;
  assign o_wdata = i_wdata;
  assign o_be    = i_be;
  assign o_id    = i_id;

  // Descending scan so the lowest matching port wins on overlapping windows.
  always_comb begin
    sel = SEL_W'(NB_SLAVES);
    for (int i = NB_SLAVES - 1; i >= 0; i--) begin
      if (((i_add ^ BASE[i]) & MASK[i]) == '0) sel = SEL_W'(i);
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head  = fifo_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    o_req      = '0;
    o_req[sel] = i_req & ~full;
    o_gnt      = i_gnt[sel] & i_req & ~full;
  end

  always_comb begin
    head_oh       = '0;
    head_oh[head] = 1'b1;
  end

  assign head_vld  = ~empty & i_r_valid[head];
  assign unexp_hit = empty ? |i_r_valid : |(i_r_valid & ~head_oh);
  assign push      = o_gnt;
  assign pop       = to_pend_q | head_vld;

  // A pending synthetic response overrides whatever the head port presents.
  always_comb begin
    o_r_valid = to_pend_q | head_vld;
    o_r_opc   = 1'b0;
    o_r_id    = '0;
    o_r_rdata = '0;
    if (to_pend_q) begin
      o_r_opc   = 1'b1;
      o_r_rdata = 32'hDEAD_BEEF;
    end else if (head_vld) begin
      o_r_opc   = i_r_opc[head];
      o_r_id    = i_r_id[head];
      o_r_rdata = i_r_rdata[head];
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q[PTR_W-1:0]] = sel;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (empty || pop)           cnt_d = '0;
    else if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_ONE;
    else                        cnt_d = cnt_q;

    to_pend_d   = ~to_pend_q & ~empty & ~head_vld & (cnt_q == CNT_LAST);
    err_to_d    = err_to_q | to_pend_d;
    err_unexp_d = err_unexp_q | unexp_hit;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_q      <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      to_pend_q   <= 1'b0;
      err_to_q    <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      to_pend_q   <= to_pend_d;
      err_to_q    <= err_to_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  assign o_err_timeout = err_to_q;
  assign o_err_unexp   = err_unexp_q;

endmodule

// File: tb/tb_per_addr_decoder.sv
// Scoreboard bench for per_addr_decoder: directed requests push expected responses,
// a negedge monitor pops and compares every response the master sees.
module tb_per_addr_decoder;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_req;
  logic [31:0]      i_add;
  logic             i_wen;
  logic [31:0]      i_wdata;
  logic [3:0]       i_be;
  logic [4:0]       i_id;
  logic             o_gnt, o_r_valid, o_r_opc;
  logic [4:0]       o_r_id;
  logic [31:0]      o_r_rdata;
  logic [4:0]       o_req;
  logic [31:0]      o_add;
  logic             o_wen;
  logic [31:0]      o_wdata;
  logic [3:0]       o_be;
  logic [4:0]       o_id;
  logic [4:0]       i_gnt, i_r_valid, i_r_opc;
  logic [4:0][4:0]  i_r_id;
  logic [4:0][31:0] i_r_rdata;
  logic             o_err_timeout, o_err_unexp;

  typedef struct packed {
    logic        opc;
    logic [4:0]  id;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   got;

  per_addr_decoder dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_add(i_add), .i_wen(i_wen),
    .i_wdata(i_wdata), .i_be(i_be), .i_id(i_id), .o_gnt(o_gnt), .o_r_valid(o_r_valid),
    .o_r_opc(o_r_opc), .o_r_id(o_r_id), .o_r_rdata(o_r_rdata), .o_req(o_req),
    .o_add(o_add), .o_wen(o_wen), .o_wdata(o_wdata), .o_be(o_be), .o_id(o_id),
    .i_gnt(i_gnt), .i_r_valid(i_r_valid), .i_r_opc(i_r_opc), .i_r_id(i_r_id),
    .i_r_rdata(i_r_rdata), .o_err_timeout(o_err_timeout), .o_err_unexp(o_err_unexp)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_rsp(input logic opc, input logic [4:0] id, input logic [31:0] d);
    rsp_t e;
    e.opc = opc;
    e.id = id;
    e.rdata = d;
    exp_q.push_back(e);
  endtask

  task automatic resp(input int p, input logic opc, input logic [4:0] id, input logic [31:0] d);
    i_r_valid = '0;
    i_r_valid[p] = 1'b1;
    i_r_opc[p] = opc;
    i_r_id[p] = id;
    i_r_rdata[p] = d;
  endtask

  // Drives a request, checks decode and grant in that cycle, advances one cycle (request left high).
  task automatic issue(input string name, input logic [31:0] a, input logic wen,
                       input logic [4:0] id, input logic [4:0] exp_req);
    i_add = a;
    i_wen = wen;
    i_id = id;
    i_wdata = {a[15:0], 11'd0, id};
    i_be = 4'hF;
    i_req = 1'b1;
    @(negedge i_clk);
    chk({name, "_o_req"}, o_req, exp_req);
    chk({name, "_o_gnt"}, o_gnt, 1'b1);
    tick();
  endtask

  always @(negedge i_clk) begin
    if (o_r_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected actual=id %0h rdata %0h required=no response", o_r_id, o_r_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_opc", o_r_opc, mon_e.opc);
        chk("resp_id", o_r_id, mon_e.id);
        chk("resp_rdata", o_r_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    i_rst_n = 1'b0; i_req = 1'b0; i_add = '0; i_wen = 1'b0; i_wdata = '0; i_be = '0; i_id = '0;
    i_gnt = '1; i_r_valid = '0; i_r_opc = '0; i_r_id = '0; i_r_rdata = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_o_req", o_req, 5'b0);
    chk("rst_o_gnt", o_gnt, 1'b0);
    chk("rst_r_valid", o_r_valid, 1'b0);
    chk("rst_r_opc", o_r_opc, 1'b0);
    chk("rst_r_id", o_r_id, 5'd0);
    chk("rst_r_rdata", o_r_rdata, 32'd0);
    chk("rst_err_timeout", o_err_timeout, 1'b0);
    chk("rst_err_unexp", o_err_unexp, 1'b0);
    i_rst_n = 1'b1;
    tick();

    // single read to port 1, answered the next cycle
    issue("rd1", 32'h1A10_1004, 1'b1, 5'd3, 5'b00010);
    expect_rsp(1'b0, 5'd3, 32'h0000_1234);
    i_req = 1'b0;
    resp(1, 1'b0, 5'd3, 32'h0000_1234);
    tick();
    i_r_valid = '0;
    @(negedge i_clk);
    chk("rd1_idle_after", o_r_valid, 1'b0);
    tick();

    // unmapped address goes to the error port
    issue("unmapped", 32'h0000_0040, 1'b1, 5'd7, 5'b10000);
    expect_rsp(1'b1, 5'd7, 32'hDEAD_BEEF);
    i_req = 1'b0;
    resp(4, 1'b1, 5'd7, 32'hDEAD_BEEF);
    tick();
    i_r_valid = '0;
    chk("unmapped_err_unexp", o_err_unexp, 1'b0);

    // fill the FIFO with writes to ports 0,2,0,2 then stall a fifth request
    issue("wr_a", 32'h1A10_0100, 1'b0, 5'd1, 5'b00001); expect_rsp(1'b0, 5'd1, 32'hA1);
    issue("wr_b", 32'h1A10_2000, 1'b0, 5'd2, 5'b00100); expect_rsp(1'b0, 5'd2, 32'hA2);
    issue("wr_c", 32'h1A10_0200, 1'b0, 5'd3, 5'b00001); expect_rsp(1'b0, 5'd3, 32'hA3);
    issue("wr_d", 32'h1A10_2004, 1'b0, 5'd4, 5'b00100); expect_rsp(1'b0, 5'd4, 32'hA4);
    i_add = 32'h1A11_0000; i_id = 5'd5; i_wen = 1'b0;
    @(negedge i_clk);
    chk("full_o_gnt", o_gnt, 1'b0);
    chk("full_o_req", o_req, 5'b0);
    tick();
    resp(0, 1'b0, 5'd1, 32'hA1);
    @(negedge i_clk);
    chk("full_pop_o_gnt", o_gnt, 1'b0);
    chk("full_pop_o_req", o_req, 5'b0);
    tick();
    i_r_valid = '0;
    @(negedge i_clk);
    chk("refill_o_req", o_req, 5'b01000);
    chk("refill_o_gnt", o_gnt, 1'b1);
    expect_rsp(1'b0, 5'd5, 32'hA5);
    tick();
    i_req = 1'b0;
    resp(2, 1'b0, 5'd2, 32'hA2); tick();
    resp(0, 1'b0, 5'd3, 32'hA3); tick();
    resp(2, 1'b0, 5'd4, 32'hA4); tick();
    resp(3, 1'b0, 5'd5, 32'hA5); tick();
    i_r_valid = '0;
    chk("inorder_err_unexp", o_err_unexp, 1'b0);
    chk("pre_to_err_timeout", o_err_timeout, 1'b0);

    // port 3 never answers: synthetic error after 16 idle cycles following the grant
    issue("to_req", 32'h1A11_0010, 1'b1, 5'd9, 5'b01000);
    expect_rsp(1'b1, 5'd0, 32'hDEAD_BEEF);
    i_req = 1'b0;
    got = 0;
    for (int k = 1; k <= 30 && got == 0; k++) begin
      @(negedge i_clk);
      if (o_r_valid) got = k;
    end
    chk("to_latency", got, 17);
    tick();
    chk("to_err_timeout", o_err_timeout, 1'b1);
    chk("to_err_unexp_before_late", o_err_unexp, 1'b0);
    resp(3, 1'b0, 5'd9, 32'h55);
    tick();
    i_r_valid = '0;
    chk("late_err_unexp", o_err_unexp, 1'b1);

    // overlapping windows: lowest index wins
    issue("ovl_0_2", 32'h1A10_0010, 1'b1, 5'd6, 5'b00001);
    expect_rsp(1'b0, 5'd6, 32'hB0);
    i_req = 1'b0;
    resp(0, 1'b0, 5'd6, 32'hB0); tick();
    i_r_valid = '0;
    issue("ovl_1_2", 32'h1A10_1FFC, 1'b1, 5'd8, 5'b00010);
    expect_rsp(1'b1, 5'd8, 32'hC0);
    i_req = 1'b0;
    resp(1, 1'b1, 5'd8, 32'hC0); tick();
    i_r_valid = '0;

    // reset with two transactions outstanding
    issue("rst_a", 32'h1A10_0100, 1'b1, 5'd11, 5'b00001);
    issue("rst_b", 32'h1A10_1000, 1'b1, 5'd12, 5'b00010);
    i_req = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrst_o_req", o_req, 5'b0);
    chk("midrst_o_gnt", o_gnt, 1'b0);
    chk("midrst_r_valid", o_r_valid, 1'b0);
    chk("midrst_err_timeout", o_err_timeout, 1'b0);
    chk("midrst_err_unexp", o_err_unexp, 1'b0);
    tick();
    i_rst_n = 1'b1;
    issue("post_rst", 32'h1A10_1008, 1'b1, 5'd13, 5'b00010);
    expect_rsp(1'b0, 5'd13, 32'hD0);
    i_req = 1'b0;
    resp(1, 1'b0, 5'd13, 32'hD0); tick();
    i_r_valid = '0;
    tick();
    chk("post_rst_err_unexp", o_err_unexp, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
